// File: rtl/escritor_serial.sv
`default_nettype none
// ============================================================================
// Module      : escritor_serial
// Description : 8N1 UART transmitter for the paddle link. On a send request
//               it snapshots both paddle positions and emits two bytes,
//               {1'b0, paddle1Y} then {1'b1, paddle2Y}, LSB first with no
//               gap between them.
// Revision    : 1.0 - initial release
// ============================================================================
module escritor_serial #(
  parameter int   CLKS_PER_BIT = 868,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [6:0] paddle1Y,
  input  logic [6:0] paddle2Y,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int              c_BW        = $clog2(CLKS_PER_BIT);
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_START = 2'd1;
  localparam logic [1:0] c_S_DATA  = 2'd2;
  localparam logic [1:0] c_S_STOP  = 2'd3;

  logic [1:0]      r_state,    w_state_nxt;
  logic [c_BW-1:0] r_baud,     w_baud_nxt;
  logic [2:0]      r_bitcnt,   w_bitcnt_nxt;
  logic            r_byte_idx, w_byte_idx_nxt;
  logic [7:0]      r_shift,    w_shift_nxt;
  logic [7:0]      r_byte1,    w_byte1_nxt;
  logic            r_tx,       w_tx_nxt;
  logic            r_busy,     w_busy_nxt;
  logic            r_done,     w_done_nxt;

  logic w_bit_end;
  logic w_accept;

  // Last cycle of the current bit period; new requests only while idle.
  assign w_bit_end = (r_baud == c_BAUD_LAST);
  assign w_accept  = send && !r_busy;

  // State register: FSM, counters, data holding and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_baud     <= '0;
      r_bitcnt   <= 3'd0;
      r_byte_idx <= 1'b0;
      r_shift    <= 8'd0;
      r_byte1    <= 8'd0;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_byte1    <= w_byte1_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic: bit timing, data shifting and byte sequencing.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = w_bit_end ? '0 : (r_baud + c_BAUD_ONE);
    w_bitcnt_nxt   = r_bitcnt;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    w_byte1_nxt    = r_byte1;
    case (r_state)
      c_S_IDLE: begin
        w_baud_nxt = '0;
        if (w_accept) begin
          // Snapshot both bytes so later input changes cannot corrupt the packet.
          w_state_nxt    = c_S_START;
          w_shift_nxt    = {1'b0, paddle1Y};
          w_byte1_nxt    = {1'b1, paddle2Y};
          w_byte_idx_nxt = 1'b0;
          w_bitcnt_nxt   = 3'd0;
        end
      end
      c_S_START: begin
        if (w_bit_end) begin
          w_state_nxt = c_S_DATA;
        end
      end
      c_S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = c_S_STOP;
          end
        end
      end
      c_S_STOP: begin
        if (w_bit_end) begin
          if (!r_byte_idx) begin
            // Second byte starts straight after the first stop bit.
            w_state_nxt    = c_S_START;
            w_shift_nxt    = r_byte1;
            w_byte_idx_nxt = 1'b1;
          end else begin
            w_state_nxt    = c_S_IDLE;
            w_byte_idx_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // Output logic: line level, busy and done computed for the coming cycle.
  always_comb begin
    w_tx_nxt   = IDLE_LEVEL;
    w_busy_nxt = (w_state_nxt != c_S_IDLE);
    w_done_nxt = (r_state == c_S_STOP) && (w_state_nxt == c_S_IDLE);
    case (w_state_nxt)
      c_S_START: w_tx_nxt = ~IDLE_LEVEL;
      c_S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:   w_tx_nxt = IDLE_LEVEL;
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_escritor_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_escritor_serial
// Description : Directed self-checking bench for escritor_serial, run with
//               four clocks per serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escritor_serial;

  logic       clk;
  logic       reset;
  logic       send;
  logic [6:0] paddle1Y;
  logic [6:0] paddle2Y;
  logic       tx;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  escritor_serial #(
    .CLKS_PER_BIT(4),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .send    (send),
    .paddle1Y(paddle1Y),
    .paddle2Y(paddle2Y),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle and record the line mid-bit plus busy/done
  // activity for 82 cycles after acceptance. Frame bit 0 is the byte0 start
  // bit, bit 19 the byte1 stop bit. Optionally pokes a new request mid-packet.
  task automatic run_packet(input logic [6:0] p1, input logic [6:0] p2,
                            input int poke_at, output logic [19:0] bits,
                            output int busy_cnt, output int done_cnt,
                            output int done_at);
    bits     = '0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    paddle1Y = p1;
    paddle2Y = p2;
    send     = 1'b1;
    tick();
    send = 1'b0;
    for (int n = 0; n < 82; n++) begin
      if ((n % 4 == 2) && (n < 80)) bits[n/4] = tx;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == poke_at) begin
        paddle1Y = 7'd10;
        send     = 1'b1;
      end else begin
        send = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    send = 1'b0;
    paddle1Y = 7'd0;
    paddle2Y = 7'd0;
    repeat (3) tick();
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL idle_line bad_cycles got=%0d exp=0", bad); end
  endtask

  task automatic test_basic();
    logic [19:0] bits;
    int bc, dc, da;
    // 0x32 then 0xD0, each framed start 0 / stop 1
    run_packet(7'd50, 7'd80, -1, bits, bc, dc, da);
    tests++;
    if (bits !== 20'b1_11010000_0_1_00110010_0) begin
      fails++; $display("FAIL basic_frame got=%b exp=%b", bits, 20'b1_11010000_0_1_00110010_0);
    end
    tests++;
    if (bc !== 80) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=80", bc); end
    tests++;
    if (dc !== 1) begin fails++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
    tests++;
    if (da !== 80) begin fails++; $display("FAIL basic_done_cycle got=%0d exp=80", da); end
  endtask

  task automatic test_ignore_busy();
    logic [19:0] bits;
    int bc, dc, da, bad;
    run_packet(7'd50, 7'd80, 30, bits, bc, dc, da);
    tests++;
    if (bits !== 20'b1_11010000_0_1_00110010_0) begin
      fails++; $display("FAIL ignore_frame got=%b exp=%b", bits, 20'b1_11010000_0_1_00110010_0);
    end
    tests++;
    if (bc !== 80) begin fails++; $display("FAIL ignore_busy_cycles got=%0d exp=80", bc); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
      tick();
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL ignore_no_second_packet bad_cycles got=%0d exp=0", bad); end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] bits;
    int bc, dc, da, bad;
    paddle1Y = 7'd0;
    paddle2Y = 7'd127;
    send = 1'b1;
    tick();
    send = 1'b0;
    repeat (8) tick();
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL midframe_pre tx/busy got=%b%b exp=01", tx, busy);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midframe_abort tx/busy/done got=%b%b%b exp=100", tx, busy, done);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL midframe_no_resume bad_cycles got=%0d exp=0", bad); end
    // 0x55 then 0xAA
    run_packet(7'h55, 7'h2A, -1, bits, bc, dc, da);
    tests++;
    if (bits !== 20'b1_10101010_0_1_01010101_0) begin
      fails++; $display("FAIL midframe_new_frame got=%b exp=%b", bits, 20'b1_10101010_0_1_01010101_0);
    end
    tests++;
    if (bc !== 80 || dc !== 1) begin
      fails++; $display("FAIL midframe_new_busy_done got=%0d/%0d exp=80/1", bc, dc);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_bits;
    int tx_bad, busy_bad, done_bad, k, m, waited;
    // 0x05 then 0x83, repeating every 81 cycles
    exp_bits = 20'b1_10000011_0_1_00000101_0;
    tx_bad = 0;
    busy_bad = 0;
    done_bad = 0;
    paddle1Y = 7'h05;
    paddle2Y = 7'h03;
    send = 1'b1;
    tick();
    for (int n = 0; n < 243; n++) begin
      k = n / 81;
      m = n % 81;
      if (m == 80) begin
        if (tx !== 1'b1) tx_bad++;
        if (busy !== 1'b0) busy_bad++;
        if (done !== 1'b1) done_bad++;
      end else begin
        if (tx !== exp_bits[m/4]) tx_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (done !== 1'b0) done_bad++;
      end
      tick();
    end
    tests++;
    if (tx_bad !== 0) begin fails++; $display("FAIL b2b_tx bad_cycles got=%0d exp=0 (k=%0d)", tx_bad, k); end
    tests++;
    if (busy_bad !== 0) begin fails++; $display("FAIL b2b_busy bad_cycles got=%0d exp=0", busy_bad); end
    tests++;
    if (done_bad !== 0) begin fails++; $display("FAIL b2b_done bad_cycles got=%0d exp=0", done_bad); end
    send = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_drain busy got=%b exp=0", busy); end
    repeat (3) tick();
  endtask

  task automatic test_boundary();
    logic [19:0] bits;
    int bc, dc, da;
    // 0x7F then 0x80
    run_packet(7'd127, 7'd0, -1, bits, bc, dc, da);
    tests++;
    if (bits !== 20'b1_10000000_0_1_01111111_0) begin
      fails++; $display("FAIL boundary_frame got=%b exp=%b", bits, 20'b1_10000000_0_1_01111111_0);
    end
    tests++;
    if (bc !== 80 || dc !== 1 || da !== 80) begin
      fails++; $display("FAIL boundary_timing busy/done/at got=%0d/%0d/%0d exp=80/1/80", bc, dc, da);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_reset_midframe();
    test_back_to_back();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
